// File: rtl/riscv_pkg.sv
// Shared RV32 memory-stage definitions: opcodes, funct3 encodings,
// FSM state type and access-size helpers.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [0:0] state_t;
  localparam state_t S_IDLE   = 1'b0;
  localparam state_t S_ACCESS = 1'b1;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Unsigned variants only exist for loads; anything
  // unrecognised is a word access.
  function automatic size_t acc_size(
    input logic [2:0] f3,
    input logic       st
  );
    size_t sz;
    sz = SZ_W;
    if (f3 == F3_B || (!st && f3 == F3_BU))
      sz = SZ_B;
    else if (f3 == F3_H || (!st && f3 == F3_HU))
      sz = SZ_H;
    return sz;
  endfunction

endpackage

// File: rtl/mem_stage_lsu.sv
// lsu_align: byte enables, store lane replication, load shift/extend.
// Ports: i_addr/i_func_3/i_store/i_wdata/i_rdata in; o_addr/o_be/o_wdata/o_rdata/o_misalign out.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_func_3,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_addr,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  size_t       w_sz;
  logic [1:0]  w_off;
  logic [31:0] w_shift;
  logic        w_sx;

  assign w_sz   = acc_size(i_func_3, i_store);
  assign o_addr = {i_addr[31:2], 2'b00};
  assign w_sx   = ~i_func_3[2];

  assign o_misalign =
    (w_sz == SZ_H && i_addr[0]) ||
    (w_sz == SZ_W && |i_addr[1:0]);

  // Misaligned offsets are rounded down to the access size.
  always_comb begin
    w_off   = 2'b00;
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    unique case (w_sz)
      SZ_B: begin
        w_off   = i_addr[1:0];
        o_be    = 4'b0001 << w_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        w_off   = {i_addr[1], 1'b0};
        o_be    = 4'b0011 << w_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = i_rdata >> {w_off, 3'b000};

  always_comb begin
    o_rdata = w_shift;
    unique case (w_sz)
      SZ_B: o_rdata = {{24{w_sx & w_shift[7]}},
                       w_shift[7:0]};
      SZ_H: o_rdata = {{16{w_sx & w_shift[15]}},
                       w_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory stage: pass-through or IDLE/ACCESS load/store handshake.
// Ports: clk/rst, ex_mem i_*, stall, dmem_* bus, mem_wb o_*. Option: MISALIGN_TRAP_EN.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_alu_out,
  input  logic [XLEN-1:0] i_rs_2,
  input  logic [4:0]      i_rd_num,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_func_3,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            o_valid,
  output logic [XLEN-1:0] o_mem_out,
  output logic [XLEN-1:0] o_alu_out,
  output logic [4:0]      o_rd_num,
  output logic            o_op_type,
  output logic            o_reg_we,
  output logic            o_misalign
);

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_store;

  logic        w_acc;
  logic        w_ldst;
  logic        w_st;
  logic        w_trap;
  logic        w_go;
  logic [31:0] w_a_addr;
  logic [31:0] w_a_wdata;
  logic [2:0]  w_a_f3;
  logic        w_a_st;
  logic [31:0] w_al_addr;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_ld;
  logic        w_mis;

  assign w_acc  = (r_state == S_ACCESS);
  assign w_st   = (i_opcode == OP_STORE);
  assign w_ldst = i_valid &
                  ((i_opcode == OP_LOAD) | w_st);
  assign w_trap = TRAP_EN & w_ldst & w_mis;
  assign w_go   = w_ldst & ~w_trap;

  // Live inputs feed the aligner in IDLE (misalign check),
  // latched values drive the bus in ACCESS.
  assign w_a_addr  = w_acc ? r_addr  : i_alu_out;
  assign w_a_wdata = w_acc ? r_wdata : i_rs_2;
  assign w_a_f3    = w_acc ? r_f3    : i_func_3;
  assign w_a_st    = w_acc ? r_store : w_st;

  lsu_align u_align (
    .i_addr     (w_a_addr),
    .i_func_3   (w_a_f3),
    .i_store    (w_a_st),
    .i_wdata    (w_a_wdata),
    .i_rdata    (dmem_rdata),
    .o_addr     (w_al_addr),
    .o_be       (w_be),
    .o_wdata    (w_wd),
    .o_rdata    (w_ld),
    .o_misalign (w_mis)
  );

  assign stall = ~rst &
    ((~w_acc & w_go) | (w_acc & ~dmem_ack));

  assign dmem_req   = w_acc;
  assign dmem_we    = w_acc & r_store;
  assign dmem_addr  = w_acc ? w_al_addr : '0;
  assign dmem_wdata = w_acc ? w_wd : '0;
  assign dmem_be    = w_acc ? w_be : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_f3       <= '0;
      r_rd       <= '0;
      r_store    <= 1'b0;
      o_valid    <= 1'b0;
      o_mem_out  <= '0;
      o_alu_out  <= '0;
      o_rd_num   <= '0;
      o_op_type  <= 1'b0;
      o_reg_we   <= 1'b0;
      o_misalign <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_op_type  <= 1'b0;
      o_reg_we   <= 1'b0;
      o_misalign <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state <= S_ACCESS;
            r_addr  <= i_alu_out;
            r_wdata <= i_rs_2;
            r_f3    <= i_func_3;
            r_rd    <= i_rd_num;
            r_store <= w_st;
          end else begin
            o_valid    <= i_valid;
            o_alu_out  <= i_alu_out;
            o_rd_num   <= i_rd_num;
            o_mem_out  <= '0;
            o_misalign <= w_trap;
            o_reg_we   <= i_valid & ~w_trap &
                          (|i_rd_num);
          end
        end
        S_ACCESS: begin
          if (dmem_ack) begin
            r_state   <= S_IDLE;
            o_valid   <= 1'b1;
            o_alu_out <= r_addr;
            o_rd_num  <= r_rd;
            o_op_type <= ~r_store;
            o_reg_we  <= ~r_store & (|r_rd);
            o_mem_out <= r_store ? '0 : w_ld;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-level memory reference model,
// randomized instruction stream, directed corner cases.
module tb_mem_stage;
  import riscv_pkg::*;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_alu_out;
  logic [31:0] i_rs_2;
  logic [4:0]  i_rd_num;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        o_valid;
  logic [31:0] o_mem_out;
  logic [31:0] o_alu_out;
  logic [4:0]  o_rd_num;
  logic        o_op_type;
  logic        o_reg_we;
  logic        o_misalign;

  mem_stage #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_alu_out  (i_alu_out),
    .i_rs_2     (i_rs_2),
    .i_rd_num   (i_rd_num),
    .i_opcode   (i_opcode),
    .i_func_3   (i_func_3),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .o_valid    (o_valid),
    .o_mem_out  (o_mem_out),
    .o_alu_out  (o_alu_out),
    .o_rd_num   (o_rd_num),
    .o_op_type  (o_op_type),
    .o_reg_we   (o_reg_we),
    .o_misalign (o_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        op;
    logic        we;
    logic        mis;
    logic        chk_mem;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ref_mem [0:63];
  logic [31:0] wmem [0:15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious o_valid: got 1 want 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("o_alu_out", o_alu_out, e.alu);
        chk("o_rd_num", 32'(o_rd_num), 32'(e.rd));
        chk("o_op_type", 32'(o_op_type), 32'(e.op));
        chk("o_reg_we", 32'(o_reg_we), 32'(e.we));
        chk("o_misalign", 32'(o_misalign),
            32'(e.mis));
        if (e.chk_mem)
          chk("o_mem_out", o_mem_out, e.mem);
      end
    end
  end

  function automatic int nbytes(
    input logic [2:0] f3, input bit st);
    if (f3 == 3'd0 || (!st && f3 == 3'd4))
      return 1;
    if (f3 == 3'd1 || (!st && f3 == 3'd5))
      return 2;
    return 4;
  endfunction

  // Called at a negedge; returns at the negedge where the
  // next instruction may be presented.
  task automatic issue(input logic v,
                       input logic [6:0] op,
                       input logic [2:0] f3,
                       input logic [31:0] addr,
                       input logic [31:0] rs2,
                       input logic [4:0] rd,
                       input int lat);
    bit          mem, st, mis, trap, go, sgn;
    int          nb;
    logic [31:0] ea, wa, val, wexp;
    logic [3:0]  beexp;
    exp_t        e;
    st   = (op == OP_STORE);
    mem  = v && (op == OP_LOAD || st);
    nb   = nbytes(f3, st);
    mis  = (addr % nb) != 0;
    trap = mem && mis && TRAP;
    go   = mem && !trap;
    sgn  = !st && (f3 == 3'd0 || f3 == 3'd1);
    ea   = addr & ~(32'(nb) - 1);
    wa   = addr & ~32'h3;
    beexp = 4'((32'h1 << nb) - 1) << (ea - wa);
    wexp = (nb == 1) ? {4{rs2[7:0]}} :
           (nb == 2) ? {2{rs2[15:0]}} : rs2;
    val = 0;
    if (go) begin
      for (int b = 0; b < nb; b++) begin
        if (st)
          ref_mem[(ea + b) & 63] = rs2[8*b +: 8];
        else
          val[8*b +: 8] = ref_mem[(ea + b) & 63];
      end
      if (!st && sgn && nb < 4 && val[8*nb-1])
        val = val | ~((32'h1 << (8*nb)) - 1);
    end
    e.alu = addr;
    e.rd  = rd;
    e.op  = go && !st;
    e.we  = (!mem || (go && !st)) && rd != 0;
    e.mis = trap;
    e.mem = val;
    e.chk_mem = go && !st;
    if (v) sb.push_back(e);
    i_valid   = v;
    i_opcode  = op;
    i_func_3  = f3;
    i_alu_out = addr;
    i_rs_2    = rs2;
    i_rd_num  = rd;
    dmem_ack  = 1'b0;
    #1;
    chk("stall_issue", 32'(stall), 32'(go));
    chk("dmem_req_idle", 32'(dmem_req), 0);
    if (!go) begin
      @(negedge clk);
      return;
    end
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk("dmem_req", 32'(dmem_req), 1);
      chk("dmem_addr", dmem_addr, wa);
      chk("dmem_be", 32'(dmem_be), 32'(beexp));
      chk("dmem_we", 32'(dmem_we), 32'(st));
      if (st) chk("dmem_wdata", dmem_wdata, wexp);
      if (c == lat) begin
        dmem_ack   = 1'b1;
        dmem_rdata = wmem[wa[5:2]];
        if (st)
          for (int b = 0; b < 4; b++)
            if (dmem_be[b])
              wmem[wa[5:2]][8*b +: 8] =
                dmem_wdata[8*b +: 8];
        #1;
        chk("stall_ack", 32'(stall), 0);
      end else begin
        #1;
        chk("stall_wait", 32'(stall), 1);
      end
    end
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
  endtask

  task automatic preload(input int idx,
                         input logic [31:0] w);
    wmem[idx] = w;
    for (int b = 0; b < 4; b++)
      ref_mem[4*idx + b] = w[8*b +: 8];
  endtask

  initial begin
    logic [6:0]  op;
    int          r;
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_alu_out  = '0;
    i_rs_2     = '0;
    i_rd_num   = '0;
    i_opcode   = '0;
    i_func_3   = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    repeat (3) @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_o_alu_out", o_alu_out, 0);
    chk("rst_o_reg_we", 32'(o_reg_we), 0);
    chk("rst_o_misalign", 32'(o_misalign), 0);
    chk("rst_dmem_be", 32'(dmem_be), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(1, 7'b0110011, 3'd0, 32'h10, 0, 5'd5, 0);
    preload(0, 32'h80FF_0000);
    issue(1, OP_LOAD, F3_B, 32'h103, 0, 5'd7, 3);
    issue(1, OP_STORE, F3_H, 32'h22,
          32'h1234ABCD, 5'd9, 1);
    issue(1, OP_LOAD, F3_W, 32'h6, 0, 5'd3, 0);
    issue(1, OP_LOAD, F3_HU, 32'h2, 0, 5'd0, 2);
    issue(0, OP_LOAD, F3_W, 32'h8, 0, 5'd4, 0);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? OP_LOAD :
           (r < 7) ? OP_STORE : 7'b0010011;
      issue(($urandom_range(0, 9) != 0),
            op, 3'($urandom), $urandom,
            $urandom, 5'($urandom),
            $urandom_range(0, 3));
    end
    i_valid = 1'b0;
    for (int t = 0; t < 20 && sb.size() != 0; t++)
      @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    i_valid   = 1'b1;
    i_opcode  = OP_LOAD;
    i_func_3  = F3_W;
    i_alu_out = 32'h40;
    i_rd_num  = 5'd6;
    @(negedge clk);
    chk("ra_req", 32'(dmem_req), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("ra_req_after", 32'(dmem_req), 0);
    chk("ra_stall", 32'(stall), 0);
    chk("ra_o_valid", 32'(o_valid), 0);
    rst      = 1'b0;
    i_valid  = 1'b0;
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("ra_stray_valid", 32'(o_valid), 0);
    chk("ra_stray_req", 32'(dmem_req), 0);
    @(negedge clk);
    chk("ra_stray_valid2", 32'(o_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 There SHALL be one clock and synchronous, active-high reset; ports as follows:
  clk  input  1  rising-edge clock
  rst  input  1  synchronous active-high reset
  i_valid  input  1  ex_mem entry holds a valid instruction
  i_alu_out  input  32  ALU result / effective address
  i_rs_2  input  32  store data
  i_rd_num  input  5  destination register
  i_opcode  input  7  instruction opcode
  i_func_3  input  3  funct3
  stall  output  1  hold if/id, id/ex, ex/mem registers
  dmem_req  output  1  data memory request
  dmem_we  output  1  write enable
  dmem_addr  output  32  word-aligned address, bits [1:0]=0
  dmem_wdata  output  32  lane-replicated store data
  dmem_be  output  4  byte enables
  dmem_ack  input  1  memory completes request this cycle
  dmem_rdata  input  32  read word, valid with dmem_ack
  o_valid  output  1  mem_wb entry valid
  o_mem_out  output  32  aligned, extended load data
  o_alu_out  output  32  registered i_alu_out
  o_rd_num  output  5  registered destination
  o_op_type  output  1  1 = load result, 0 = ALU result
  o_reg_we  output  1  writeback enable
  o_misalign  output  1  misaligned access flag (MISALIGN_TRAP_EN only)

Function
REQ-003 Opcode 0000011 = load, 0100011 = store; all others are pass-through.
REQ-004 Pass-through: outputs SHALL register the inputs at the next edge (1-cycle latency); o_op_type=0, stall=0.
REQ-005 FSM states SHALL be IDLE and ACCESS; IDLE->ACCESS on i_valid with load/store, latching address, data, func3, rd, and kind.
REQ-006 In ACCESS, dmem_req=1 with stable address/we/be/wdata until dmem_ack; ACCESS->IDLE on the dmem_ack edge.
REQ-007 stall SHALL be (IDLE & i_valid & load/store) | (ACCESS & ~dmem_ack), combinational.
REQ-008 Load/store result SHALL appear on o_valid at the edge after dmem_ack; minimum latency is 2 cycles; o_valid=0 in all other cycles.
REQ-009 dmem_be: SB 0001, SH 0011, SW 1111, shifted left by addr[1:0]; dmem_wdata replicates byte/half across lanes.
REQ-010 Loads SHALL shift dmem_rdata right by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; reserved funct3 is treated as word.
REQ-011 o_reg_we SHALL be 0 for stores, when rd_num==0, and when o_valid=0.
REQ-012 Back-to-back memory ops: a new op SHALL be accepted from IDLE in the cycle after the previous ACCESS exits.

Reset
REQ-013 On rst at an edge, state=IDLE; all outputs SHALL be 0, including during ACCESS; an outstanding dmem_ack after reset SHALL be ignored.

Configuration
REQ-014 With MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL skip ACCESS and produce o_valid=1, o_misalign=1, o_reg_we=0 one cycle later, with no dmem_req.
REQ-015 Without MISALIGN_TRAP_EN: o_misalign is tied to 0; misaligned addresses SHALL be aligned down to the access size and performed.

Structure
REQ-016 Shared package riscv_pkg SHALL hold the opcode constants (OP_LOAD, OP_STORE), funct3 encodings, and the FSM state type.
REQ-017 Lane logic (byte enables, store replication, load shift/extend) SHALL be in combinational sub-module lsu_align.

Verification
REQ-018 ADD: alu_out=0x10, rd=5 -> next cycle o_valid=1, o_alu_out=0x10, o_op_type=0, o_reg_we=1, stall=0.
REQ-019 LB at addr 0x103 with rdata=0x80FF_0000 and ack after 3 cycles -> stall=1 for 4 cycles, o_mem_out=0xFFFF_FF80.
REQ-020 SH with addr 0x22 and rs_2=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x20, o_reg_we=0.
REQ-021 LW at addr 0x6 -> with MISALIGN_TRAP_EN: o_misalign=1, no dmem_req; without it: dmem_addr=0x4, and the load completes.
REQ-022 rst asserted in ACCESS -> next cycle dmem_req=0, stall=0, o_valid=0; a later ack produces no output.
